// File: rtl/tile_pixel_gen_pkg.sv
// Shared definitions for the tile pixel generator: default geometry,
// scanner state encoding and a small FIFO write-acceptance helper.
package tile_pixel_gen_pkg;

    localparam int COORD_W_DEF    = 10;
    localparam int TILE_SHIFT_DEF = 2;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    // A push is accepted when there is room, or when a pop frees a slot
    // in the same cycle.
    function automatic logic fifo_push_ok(input logic push, input logic full, input logic pop);
        return push && (!full || pop);
    endfunction

endpackage

// File: rtl/tile_fifo.sv
// Synchronous tile FIFO with show-ahead read data, occupancy level and a
// one-cycle drop indication when a push is refused.
module tile_fifo
    import tile_pixel_gen_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [LW-1:0]    level,
    output logic             drop
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_s;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full_s   = (level_q == LW'(DEPTH));
    assign empty    = (level_q == LW'(0));
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign wr_en_s  = fifo_push_ok(push, full_s, pop && !empty);
    assign rd_en_s  = pop && !empty;
    assign drop     = push && !wr_en_s;

    // Next pointer and occupancy values from the accepted push/pop pair.
    always_comb begin
        wr_ptr_d = wr_en_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = rd_en_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({wr_en_s, rd_en_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            level_q  <= LW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/tile_pixel_gen.sv
// Tile-to-pixel expander: buffers incoming tiles, scans each one in
// row-major order with a valid/ready handshake and turns the upstream
// completion level into a single end-of-primitive pulse after the last pixel.
module tile_pixel_gen
    import tile_pixel_gen_pkg::*;
#(
    parameter int COORD_W    = COORD_W_DEF,
    parameter int TILE_SHIFT = TILE_SHIFT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int PIX_W     = COORD_W + TILE_SHIFT,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tile_valid,
    input  logic [COORD_W-1:0] tile_x,
    input  logic [COORD_W-1:0] tile_y,
    input  logic               done_in,
    input  logic               pix_ready,
    output logic               pix_valid,
    output logic [PIX_W-1:0]   pix_x,
    output logic [PIX_W-1:0]   pix_y,
    output logic               pix_last,
    output logic               done_out,
    output logic               busy,
    output logic               overflow,
    output logic [LVL_W-1:0]   fifo_level
);

    scan_state_e             state_q, state_d;
    logic [COORD_W-1:0]      base_x_q, base_x_d;
    logic [COORD_W-1:0]      base_y_q, base_y_d;
    logic [TILE_SHIFT-1:0]   ox_q, ox_d;
    logic [TILE_SHIFT-1:0]   oy_q, oy_d;
    logic                    pix_last_q, pix_last_d;
    logic                    done_in_q, done_in_d;
    logic                    pending_q, pending_d;
    logic                    done_out_q, done_out_d;
    logic                    overflow_q, overflow_d;

    logic                    pop_s;
    logic                    empty_s;
    logic                    drop_s;
    logic [2*COORD_W-1:0]    head_s;
    logic                    rise_s;
    logic                    fire_s;

    tile_fifo #(
        .WIDTH (2*COORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tile_valid),
        .push_data ({tile_x, tile_y}),
        .pop       (pop_s),
        .pop_data  (head_s),
        .empty     (empty_s),
        .level     (fifo_level),
        .drop      (drop_s)
    );

    // Scanner FSM: load a tile from the FIFO, step offsets on each handshake,
    // and chain straight into the next tile when the last pixel is taken.
    always_comb begin
        state_d  = state_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        pop_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s    = 1'b1;
                    base_x_d = head_s[2*COORD_W-1:COORD_W];
                    base_y_d = head_s[COORD_W-1:0];
                    ox_d     = TILE_SHIFT'(0);
                    oy_d     = TILE_SHIFT'(0);
                    state_d  = ST_SCAN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (pix_ready) begin
                    if (pix_last_q) begin
                        if (!empty_s) begin
                            pop_s    = 1'b1;
                            base_x_d = head_s[2*COORD_W-1:COORD_W];
                            base_y_d = head_s[COORD_W-1:0];
                            ox_d     = TILE_SHIFT'(0);
                            oy_d     = TILE_SHIFT'(0);
                            state_d  = ST_SCAN;
                        end else begin
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        ox_d = ox_q + TILE_SHIFT'(1);
                        if (&ox_q) begin
                            oy_d = oy_q + TILE_SHIFT'(1);
                        end else begin
                            oy_d = oy_q;
                        end
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pix_last_d = (state_d == ST_SCAN) && (&ox_d) && (&oy_d);
    end

    // Completion handling: a rising done_in arms a pending pulse that fires
    // once the scanner will be idle with nothing buffered or arriving.
    always_comb begin
        done_in_d  = done_in;
        rise_s     = done_in && !done_in_q;
        fire_s     = (pending_q || rise_s) && (state_d == ST_IDLE) && empty_s && !tile_valid;
        done_out_d = fire_s;
        if (fire_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q || rise_s;
        end
        overflow_d = overflow_q || drop_s;
    end

    // State, pixel and completion registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_x_q   <= COORD_W'(0);
            base_y_q   <= COORD_W'(0);
            ox_q       <= TILE_SHIFT'(0);
            oy_q       <= TILE_SHIFT'(0);
            pix_last_q <= 1'b0;
            done_in_q  <= 1'b0;
            pending_q  <= 1'b0;
            done_out_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_x_q   <= base_x_d;
            base_y_q   <= base_y_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            pix_last_q <= pix_last_d;
            done_in_q  <= done_in_d;
            pending_q  <= pending_d;
            done_out_q <= done_out_d;
            overflow_q <= overflow_d;
        end
    end

    assign pix_valid = (state_q == ST_SCAN);
    assign pix_x     = {base_x_q, ox_q};
    assign pix_y     = {base_y_q, oy_q};
    assign pix_last  = pix_last_q;
    assign done_out  = done_out_q;
    assign overflow  = overflow_q;
    assign busy      = (fifo_level != LVL_W'(0)) || (state_q == ST_SCAN) || pending_q;

endmodule

// File: tb/tb_tile_pixel_gen.sv
// Directed bench for tile_pixel_gen with hand-computed pixel sequences.
module tb_tile_pixel_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        tile_valid;
    logic [9:0]  tile_x;
    logic [9:0]  tile_y;
    logic        done_in;
    logic        pix_ready;
    logic        pix_valid;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        pix_last;
    logic        done_out;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_level;

    int n_vec  = 0;
    int n_miss = 0;

    logic [9:0] exp_tx[$];
    logic [9:0] exp_ty[$];

    int bubbles;
    int peak_lvl;
    int dones;

    tile_pixel_gen #(
        .COORD_W    (10),
        .TILE_SHIFT (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tile_valid (tile_valid),
        .tile_x     (tile_x),
        .tile_y     (tile_y),
        .done_in    (done_in),
        .pix_ready  (pix_ready),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_last   (pix_last),
        .done_out   (done_out),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tile(input logic [9:0] x, input logic [9:0] y);
        tile_valid = 1'b1;
        tile_x     = x;
        tile_y     = y;
        exp_tx.push_back(x);
        exp_ty.push_back(y);
        tick();
        tile_valid = 1'b0;
    endtask

    // Consume n_pix pixels against the expected tile list, ready driven from
    // a 4-cycle pattern; checks coordinates, pix_last and stall stability.
    task automatic drain(input int n_pix, input int budget, input logic [3:0] rdy_pat, input string tag);
        int          k = 0;
        int          cyc = 0;
        int          t;
        int          off;
        logic        started = 1'b0;
        logic        prev_stall = 1'b0;
        logic [11:0] px_prev = 12'd0;
        logic [11:0] py_prev = 12'd0;
        logic [11:0] ex;
        logic [11:0] ey;
        bubbles  = 0;
        peak_lvl = 0;
        dones    = 0;
        while (k < n_pix && cyc < budget) begin
            pix_ready = rdy_pat[cyc % 4];
            if (int'(fifo_level) > peak_lvl) peak_lvl = int'(fifo_level);
            if (done_out) dones++;
            if (pix_valid) begin
                started = 1'b1;
                if (prev_stall) begin
                    check_val({tag, "_hold_x"}, 32'(pix_x), 32'(px_prev));
                    check_val({tag, "_hold_y"}, 32'(pix_y), 32'(py_prev));
                end
                t   = k / 16;
                off = k % 16;
                ex  = {exp_tx[t], off[1:0]};
                ey  = {exp_ty[t], off[3:2]};
                check_val({tag, "_px"}, 32'(pix_x), 32'(ex));
                check_val({tag, "_py"}, 32'(pix_y), 32'(ey));
                check_val({tag, "_last"}, 32'(pix_last), 32'(off == 15));
                prev_stall = !pix_ready;
                px_prev    = pix_x;
                py_prev    = pix_y;
                if (pix_ready) k++;
            end else begin
                if (started) bubbles++;
                prev_stall = 1'b0;
            end
            tick();
            cyc++;
        end
        check_val({tag, "_count"}, 32'(k), 32'(n_pix));
        pix_ready = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        tile_valid = 1'b0;
        tile_x     = 10'd0;
        tile_y     = 10'd0;
        done_in    = 1'b0;
        pix_ready  = 1'b1;
        #2;
        check_val("rst_valid", 32'(pix_valid), 32'd0);
        check_val("rst_x", 32'(pix_x), 32'd0);
        check_val("rst_y", 32'(pix_y), 32'd0);
        check_val("rst_last", 32'(pix_last), 32'd0);
        check_val("rst_done", 32'(done_out), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);
        check_val("rst_lvl", 32'(fifo_level), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single tile (3,5): latency, 16 pixels, then done pulse.
        push_tile(10'd3, 10'd5);
        check_val("t1_lvl", 32'(fifo_level), 32'd1);
        check_val("t1_val0", 32'(pix_valid), 32'd0);
        check_val("t1_busy", 32'(busy), 32'd1);
        tick();
        check_val("t1_val1", 32'(pix_valid), 32'd1);
        drain(16, 40, 4'b1111, "t1");
        check_val("t1_idle", 32'(pix_valid), 32'd0);
        check_val("t1_busy_end", 32'(busy), 32'd0);
        done_in = 1'b1;
        tick();
        check_val("t1_done_hi", 32'(done_out), 32'd1);
        tick();
        check_val("t1_done_lo", 32'(done_out), 32'd0);
        done_in = 1'b0;
        tick();
        exp_tx.delete();
        exp_ty.delete();

        // Two tiles on consecutive cycles: 32 pixels without a bubble.
        push_tile(10'd3, 10'd5);
        push_tile(10'd7, 10'd2);
        drain(32, 60, 4'b1111, "t2");
        check_val("t2_bubbles", 32'(bubbles), 32'd0);
        check_val("t2_peak", 32'(peak_lvl), 32'd1);
        exp_tx.delete();
        exp_ty.delete();
        tick();

        // Stall pattern 1,0,0,1 with held pixels.
        push_tile(10'd1, 10'd1);
        drain(16, 80, 4'b1001, "t3");
        check_val("t3_idle", 32'(pix_valid), 32'd0);
        exp_tx.delete();
        exp_ty.delete();
        tick();

        // Overflow: six tiles with downstream stalled.
        pix_ready  = 1'b0;
        tile_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tile_x = 10'(10 + i);
            tile_y = 10'(20 + i);
            if (i < 5) begin
                exp_tx.push_back(tile_x);
                exp_ty.push_back(tile_y);
            end
            if (i == 5) check_val("t4_ovf_pre", 32'(overflow), 32'd0);
            tick();
        end
        tile_valid = 1'b0;
        check_val("t4_ovf", 32'(overflow), 32'd1);
        check_val("t4_lvl", 32'(fifo_level), 32'd4);
        tick();
        tick();
        check_val("t4_ovf_sticky", 32'(overflow), 32'd1);
        drain(80, 200, 4'b1111, "t4");
        tick();
        check_val("t4_no6th", 32'(pix_valid), 32'd0);
        check_val("t4_lvl_end", 32'(fifo_level), 32'd0);
        check_val("t4_ovf_end", 32'(overflow), 32'd1);
        exp_tx.delete();
        exp_ty.delete();

        // done_in rising with a tile: one pulse after its last pixel.
        done_in = 1'b1;
        push_tile(10'd2, 10'd9);
        drain(16, 40, 4'b1111, "t5");
        check_val("t5_early_done", 32'(dones), 32'd0);
        check_val("t5_done_hi", 32'(done_out), 32'd1);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done_out) dones++;
        end
        check_val("t5_single", 32'(dones), 32'd0);
        done_in = 1'b0;
        tick();
        exp_tx.delete();
        exp_ty.delete();

        // Reset during a scan with a second tile buffered.
        push_tile(10'd6, 10'd8);
        push_tile(10'd9, 10'd9);
        for (int i = 0; i < 7; i++) tick();
        check_val("t6_px7_x", 32'(pix_x), 32'd27);
        check_val("t6_px7_y", 32'(pix_y), 32'd33);
        #1;
        rst = 1'b1;
        #1;
        check_val("t6_rst_valid", 32'(pix_valid), 32'd0);
        check_val("t6_rst_x", 32'(pix_x), 32'd0);
        check_val("t6_rst_y", 32'(pix_y), 32'd0);
        check_val("t6_rst_lvl", 32'(fifo_level), 32'd0);
        check_val("t6_rst_busy", 32'(busy), 32'd0);
        check_val("t6_rst_ovf", 32'(overflow), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        exp_tx.delete();
        exp_ty.delete();
        push_tile(10'd4, 10'd4);
        drain(16, 40, 4'b1111, "t6");
        tick();
        check_val("t6_idle", 32'(pix_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
